plataform_hole_array: RTL and testbench
=======================================

// Module: plataform_hole_array
// PURPOSE
//  Moves N_HOLES independent holes horizontally across one platform row; the next generation of the
//  single-hole mover. Adds per-hole state, bounce or wrap edge mode, a runtime speed step, pause,
//  edge clamping, and a registered pixel query "is x inside any hole". Sits between the game-tick
//  domain and the platform renderer / player-collision logic.
// PARAMETERS
//  N_HOLES   2       number of holes (1..8)
//  X_W       10      coordinate width; must hold SCREEN_W+HOLE_W
//  SCREEN_W  640     platform width in pixels
//  HOLE_W    30      hole width in pixels (< SCREEN_W/N_HOLES)
//  TICK_DIV  840000  clk cycles per movement tick (>=2)
//  STEP0     3       step size after reset, pixels/tick
//  STEP_MAX  7       saturation limit for step (< HOLE_W)
//  WRAP_MODE 0       0 = bounce at edges, 1 = wrap around edges
// PORTS
//  clk         in   1              system clock
//  rst_n       in   1              asynchronous active-low reset
//  enable      in   1              1 = movement runs; 0 = tick counter and holes frozen
//  level_up    in   1              1-cycle pulse: step <= min(step+1, STEP_MAX)
//  query_x     in   X_W            pixel column to test
//  in_hole     out  1              registered: query_x (previous cycle) is inside any hole
//  hole_start  out  N_HOLES*X_W    packed start columns, hole i at [i*X_W +: X_W]
//  hole_end    out  N_HOLES*X_W    packed hole_start+HOLE_W per hole (may exceed SCREEN_W in wrap mode)
//  tick        out  1              1-cycle pulse in the cycle the holes update
//  step_cur    out  3              current step size
// BEHAVIOUR
//  Reset (async, rst_n=0): tick counter=0, tick=0, in_hole=0, step=STEP0,
//   start[i]=i*(SCREEN_W/N_HOLES), dir[i]=right for even i, left for odd i. Release is clean on any edge.
//  Tick counter: enable=1 increments 0..TICK_DIV-1; on the clk edge where count==TICK_DIV-1, count<=0,
//   tick<=1 and all holes update on that same edge. enable=0 holds count; tick=0.
//  Bounce (WRAP_MODE=0), arithmetic in X_W+1 bits:
//   right: if start+step+HOLE_W >= SCREEN_W -> start=SCREEN_W-HOLE_W, dir=left; else start+=step.
//   left : if start <= step -> start=0, dir=right; else start-=step.
//   Holes never leave [0, SCREEN_W-HOLE_W]; no underflow.
//  Wrap (WRAP_MODE=1): dir fixed at reset value; right: start=(start+step) mod SCREEN_W;
//   left: start = start<step ? start+SCREEN_W-step : start-step.
//  Holes move independently; overlap is permitted and is not an error.
//  Speed: level_up raises step by 1, saturating at STEP_MAX. level_up in the same cycle as the update
//   edge: that update uses the old step; the new step applies from the next tick on.
//  in_hole (1-cycle latency): OR over i of hit_i;
//   hit_i = start<=x<end when end<=SCREEN_W, else x>=start || x<end-SCREEN_W.
//   Evaluated from the hole positions present in the sampling cycle.
//  hole_end is combinational from the start registers; all other outputs are registered.
// TESTING (sim with TICK_DIV=4, SCREEN_W=640, HOLE_W=30, STEP0=3, N_HOLES=2)
//  Reset -> starts {0,320}, tick pulses every 4th cycle; after 1 tick starts {3,317}, step_cur=3.
//  Bounce right: force hole0 start=608, tick -> start=610, dir left; next tick -> 607.
//  Bounce left: hole1 at 2 moving left, tick -> start=0, dir right; next tick -> 3.
//  WRAP_MODE=1: hole0 at 638 moving right -> 1; query_x=5 -> in_hole=1 one cycle later; query_x=40 -> 0.
//  level_up x6 -> step_cur=7, saturated; level_up on the tick edge -> that tick moves by old step.
//  enable=0 for 20 cycles -> no tick, positions unchanged; rst_n low mid-count -> immediate reset values.

Source files
------------

// File: rtl/plataform_hole_array.sv
// ----------------------------------------------------------------------------
// plataform_hole_array
//   Moves N_HOLES independent holes horizontally across one platform row.
//   Each hole is stepped once per movement tick, either bouncing off the row
//   edges (WRAP_MODE=0) or wrapping around them (WRAP_MODE=1). The step size
//   starts at STEP0 and is raised by level_up pulses up to STEP_MAX. A
//   registered pixel query reports whether query_x lies inside any hole.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        1 = tick counter runs and holes move; 0 = everything frozen
//   level_up      1-cycle pulse, raises the step size (saturating)
//   query_x       pixel column to test
//   in_hole       registered: previous-cycle query_x is inside any hole
//   hole_start    packed hole start columns, hole i at [i*X_W +: X_W]
//   hole_end      packed hole_start + HOLE_W (combinational)
//   tick          1-cycle pulse in the cycle the holes update
//   step_cur      current step size
// ----------------------------------------------------------------------------

// One hole: position/direction state, next-position logic and hit test.
//   i_upd    advance this hole on this edge
//   i_step   step size used for the advance
//   i_x      query column
//   o_start  registered start column
//   o_end    start + HOLE_W
//   o_hit    i_x lies inside this hole (combinational)
module plataform_hole_lane #(
    parameter int X_W        = 10,
    parameter int SCREEN_W   = 640,
    parameter int HOLE_W     = 30,
    parameter int WRAP_MODE  = 0,
    parameter int INIT_START = 0,
    parameter bit INIT_RIGHT = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_upd,
    input  logic [2:0]     i_step,
    input  logic [X_W-1:0] i_x,
    output logic [X_W-1:0] o_start,
    output logic [X_W-1:0] o_end,
    output logic           o_hit
);
    // One extra bit so start+step+HOLE_W never overflows in the edge test.
    localparam logic [X_W:0]   C_SCR   = (X_W+1)'(SCREEN_W);
    localparam logic [X_W:0]   C_HOLE  = (X_W+1)'(HOLE_W);
    localparam logic [X_W-1:0] C_RMAX  = X_W'(SCREEN_W - HOLE_W);
    localparam logic [X_W-1:0] C_SCR_X = X_W'(SCREEN_W);
    localparam logic [X_W-1:0] C_HOLEX = X_W'(HOLE_W);

    logic [X_W-1:0] r_start;
    logic           r_right;
    logic [X_W:0]   w_s, w_st;
    logic [X_W-1:0] w_nxt;
    logic           w_nxt_right;
    logic [X_W-1:0] w_end;

    assign w_s  = {1'b0, r_start};
    assign w_st = {{(X_W-2){1'b0}}, i_step};

    always_comb begin
        w_nxt       = r_start;
        w_nxt_right = r_right;
        if (WRAP_MODE != 0) begin
            // Direction never changes in wrap mode; step < SCREEN_W so one
            // correction term is enough.
            if (r_right)
                w_nxt = (w_s + w_st >= C_SCR) ? X_W'(w_s + w_st - C_SCR) : X_W'(w_s + w_st);
            else
                w_nxt = (w_s < w_st) ? X_W'(w_s + C_SCR - w_st) : X_W'(w_s - w_st);
        end else begin
            if (r_right) begin
                if (w_s + w_st + C_HOLE >= C_SCR) begin
                    w_nxt       = C_RMAX;
                    w_nxt_right = 1'b0;
                end else begin
                    w_nxt = X_W'(w_s + w_st);
                end
            end else begin
                // start <= step clamps to 0, so subtraction never underflows.
                if (w_s <= w_st) begin
                    w_nxt       = '0;
                    w_nxt_right = 1'b1;
                end else begin
                    w_nxt = X_W'(w_s - w_st);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= X_W'(INIT_START);
            r_right <= INIT_RIGHT;
        end else if (i_upd) begin
            r_start <= w_nxt;
            r_right <= w_nxt_right;
        end
    end

    assign w_end   = r_start + C_HOLEX;
    assign o_start = r_start;
    assign o_end   = w_end;
    // A hole whose end runs past the row edge (wrap mode only) covers
    // [start, SCREEN_W) plus [0, end-SCREEN_W).
    assign o_hit   = (w_end <= C_SCR_X) ? ((i_x >= r_start) && (i_x < w_end))
                                        : ((i_x >= r_start) || (i_x < (w_end - C_SCR_X)));
endmodule

module plataform_hole_array #(
    parameter int N_HOLES   = 2,
    parameter int X_W       = 10,
    parameter int SCREEN_W  = 640,
    parameter int HOLE_W    = 30,
    parameter int TICK_DIV  = 840000,
    parameter int STEP0     = 3,
    parameter int STEP_MAX  = 7,
    parameter int WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     level_up,
    input  logic [X_W-1:0]           query_x,
    output logic                     in_hole,
    output logic [N_HOLES*X_W-1:0]   hole_start,
    output logic [N_HOLES*X_W-1:0]   hole_end,
    output logic                     tick,
    output logic [2:0]               step_cur
);
    localparam int           CNT_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]   C_STEP0    = 3'(STEP0);
    localparam logic [2:0]   C_STEP_MAX = 3'(STEP_MAX);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_tick;
    logic [2:0]         r_step;
    logic               r_in_hole;
    logic               w_upd;
    logic [N_HOLES-1:0] w_hit;

    assign w_upd = enable && (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_upd;
            if (enable)
                r_cnt <= w_upd ? '0 : r_cnt + 1'b1;
        end
    end

    // Lanes sample r_step before this edge, so a level_up coinciding with
    // an update takes effect from the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_step <= C_STEP0;
        else if (level_up && (r_step < C_STEP_MAX))
            r_step <= r_step + 3'd1;
    end

    for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_lane
        plataform_hole_lane #(
            .X_W        (X_W),
            .SCREEN_W   (SCREEN_W),
            .HOLE_W     (HOLE_W),
            .WRAP_MODE  (WRAP_MODE),
            .INIT_START (gi * (SCREEN_W / N_HOLES)),
            .INIT_RIGHT ((gi % 2) == 0)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_upd   (w_upd),
            .i_step  (r_step),
            .i_x     (query_x),
            .o_start (hole_start[gi*X_W +: X_W]),
            .o_end   (hole_end[gi*X_W +: X_W]),
            .o_hit   (w_hit[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_in_hole <= 1'b0;
        else
            r_in_hole <= |w_hit;
    end

    assign in_hole  = r_in_hole;
    assign tick     = r_tick;
    assign step_cur = r_step;
endmodule

// File: tb/tb_plataform_hole_array.sv
module tb_plataform_hole_array;
    localparam int XW = 10;

    logic          clk, rst_n, enable, level_up;
    logic [XW-1:0] query_x;
    logic          b_in, w_in, b_tick, w_tick;
    logic [19:0]   b_st, b_en, w_st, w_en;
    logic [2:0]    b_step, w_step;

    plataform_hole_array #(.N_HOLES(2), .X_W(XW), .SCREEN_W(640), .HOLE_W(30), .TICK_DIV(4),
                           .STEP0(3), .STEP_MAX(7), .WRAP_MODE(0)) u_bnc (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level_up(level_up), .query_x(query_x),
        .in_hole(b_in), .hole_start(b_st), .hole_end(b_en), .tick(b_tick), .step_cur(b_step));

    plataform_hole_array #(.N_HOLES(2), .X_W(XW), .SCREEN_W(640), .HOLE_W(30), .TICK_DIV(4),
                           .STEP0(3), .STEP_MAX(7), .WRAP_MODE(1)) u_wrp (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level_up(level_up), .query_x(query_x),
        .in_hole(w_in), .hole_start(w_st), .hole_end(w_en), .tick(w_tick), .step_cur(w_step));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference state, index [mode][hole], mode 0 = bounce, 1 = wrap.
    int m_s[2][2];
    bit m_r[2][2];
    int m_cnt, m_step;
    bit m_tick;

    typedef struct { bit b; bit w; } hit_t;
    hit_t q_exp[$];

    typedef struct { logic [XW-1:0] qx; bit b; bit w; } vec_t;
    vec_t tbl[15];

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int st(int m, int h);
        return (m == 0) ? int'(b_st[h*XW +: XW]) : int'(w_st[h*XW +: XW]);
    endfunction

    function automatic int en(int m, int h);
        return (m == 0) ? int'(b_en[h*XW +: XW]) : int'(w_en[h*XW +: XW]);
    endfunction

    function automatic bit mhit(int m, int x);
        bit r = 1'b0;
        for (int h = 0; h < 2; h++) begin
            int s = m_s[m][h];
            int e = s + 30;
            if (e <= 640) r |= (x >= s) && (x < e);
            else          r |= (x >= s) || (x < e - 640);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_s[m][0] = 0;   m_r[m][0] = 1'b1;
            m_s[m][1] = 320; m_r[m][1] = 1'b0;
        end
        m_cnt = 0; m_step = 3; m_tick = 1'b0;
    endtask

    task automatic mv(int m, int h);
        int s = m_s[m][h];
        if (m == 0) begin
            if (m_r[m][h]) begin
                if (s + m_step + 30 >= 640) begin s = 610; m_r[m][h] = 1'b0; end
                else s = s + m_step;
            end else begin
                if (s <= m_step) begin s = 0; m_r[m][h] = 1'b1; end
                else s = s - m_step;
            end
        end else begin
            if (m_r[m][h]) s = (s + m_step) % 640;
            else           s = (s < m_step) ? s + 640 - m_step : s - m_step;
        end
        m_s[m][h] = s;
    endtask

    // One clock: push the expected query result, advance the model across
    // the edge, then compare every output one step after the edge.
    task automatic cyc();
        hit_t e;
        bit   upd;
        e.b = mhit(0, int'(query_x));
        e.w = mhit(1, int'(query_x));
        q_exp.push_back(e);
        upd    = enable && (m_cnt == 3);
        m_tick = upd;
        if (enable) m_cnt = upd ? 0 : m_cnt + 1;
        if (upd)
            for (int m = 0; m < 2; m++)
                for (int h = 0; h < 2; h++) mv(m, h);
        if (level_up && m_step < 7) m_step++;
        @(posedge clk);
        #1;
        chk("bnc.tick", int'(b_tick), int'(m_tick));
        chk("wrp.tick", int'(w_tick), int'(m_tick));
        chk("bnc.step", int'(b_step), m_step);
        chk("wrp.step", int'(w_step), m_step);
        for (int m = 0; m < 2; m++)
            for (int h = 0; h < 2; h++) begin
                chk($sformatf("%s.start%0d", m ? "wrp" : "bnc", h), st(m, h), m_s[m][h]);
                chk($sformatf("%s.end%0d", m ? "wrp" : "bnc", h), en(m, h), m_s[m][h] + 30);
            end
        if (q_exp.size() == 0) begin
            chk("sb.empty", 0, 1);
        end else begin
            e = q_exp.pop_front();
            chk("bnc.in_hole", int'(b_in), int'(e.b));
            chk("wrp.in_hole", int'(w_in), int'(e.w));
        end
    endtask

    task automatic run_ticks(int n);
        enable = 1'b1;
        repeat (n * 4) cyc();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, ".bnc.s0"}, st(0, 0), 0);
        chk({tag, ".bnc.s1"}, st(0, 1), 320);
        chk({tag, ".wrp.s0"}, st(1, 0), 0);
        chk({tag, ".wrp.s1"}, st(1, 1), 320);
        chk({tag, ".step"}, int'(b_step), 3);
        chk({tag, ".wstep"}, int'(w_step), 3);
        chk({tag, ".tick"}, int'(b_tick | w_tick), 0);
        chk({tag, ".in_hole"}, int'(b_in | w_in), 0);
    endtask

    initial begin
        // State after 426 ticks: bounce [54,84) [265,295); wrap [638,668) [322,352)
        tbl = '{
            '{10'd5,   1'b0, 1'b1}, '{10'd27,  1'b0, 1'b1}, '{10'd28,  1'b0, 1'b0},
            '{10'd637, 1'b0, 1'b0}, '{10'd638, 1'b0, 1'b1}, '{10'd639, 1'b0, 1'b1},
            '{10'd54,  1'b1, 1'b0}, '{10'd83,  1'b1, 1'b0}, '{10'd84,  1'b0, 1'b0},
            '{10'd264, 1'b0, 1'b0}, '{10'd294, 1'b1, 1'b0}, '{10'd322, 1'b0, 1'b1},
            '{10'd351, 1'b0, 1'b1}, '{10'd352, 1'b0, 1'b0}, '{10'd40,  1'b0, 1'b0}
        };
        rst_n = 1'b0; enable = 1'b0; level_up = 1'b0; query_x = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;

        run_ticks(1);
        chk("t1.bnc.s0", st(0, 0), 3);   chk("t1.bnc.s1", st(0, 1), 317);
        chk("t1.wrp.s0", st(1, 0), 3);   chk("t1.wrp.s1", st(1, 1), 317);

        // Left bounce of hole1: 2 -> 0 -> 3
        run_ticks(105); chk("t106.bnc.s1", st(0, 1), 2);
        run_ticks(1);   chk("t107.bnc.s1", st(0, 1), 0);
        run_ticks(1);   chk("t108.bnc.s1", st(0, 1), 3);
        // Right bounce of hole0: 609 -> 610 -> 607
        run_ticks(95);  chk("t203.bnc.s0", st(0, 0), 609);
        run_ticks(1);   chk("t204.bnc.s0", st(0, 0), 610);
        run_ticks(1);   chk("t205.bnc.s0", st(0, 0), 607);
        run_ticks(221);
        chk("t426.wrp.s0", st(1, 0), 638); chk("t426.wrp.s1", st(1, 1), 322);
        chk("t426.bnc.s0", st(0, 0), 54);  chk("t426.bnc.s1", st(0, 1), 265);

        enable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            query_x = tbl[i].qx;
            cyc();
            chk($sformatf("tbl%0d.bnc.in_hole", i), int'(b_in), int'(tbl[i].b));
            chk($sformatf("tbl%0d.wrp.in_hole", i), int'(w_in), int'(tbl[i].w));
        end

        // Frozen: 20 cycles, no tick, positions unchanged
        query_x = '0;
        repeat (20) cyc();
        chk("frz.wrp.s0", st(1, 0), 638); chk("frz.bnc.s1", st(0, 1), 265);

        // Wrap across right edge 638 -> 1, then query around it
        run_ticks(1);
        chk("wrap.s0", st(1, 0), 1);
        enable = 1'b0;
        query_x = 10'd5;  cyc(); chk("q5.wrp.in_hole", int'(w_in), 1);
        query_x = 10'd40; cyc(); chk("q40.wrp.in_hole", int'(w_in), 0);

        // level_up on the update edge: this tick still uses step 3
        enable = 1'b1;
        repeat (3) cyc();
        level_up = 1'b1; cyc(); level_up = 1'b0;
        chk("lu.tick", int'(w_tick), 1);
        chk("lu.wrp.s0", st(1, 0), 4);
        chk("lu.step", int'(w_step), 4);
        run_ticks(1);
        chk("lu2.wrp.s0", st(1, 0), 8);

        // Saturation
        enable = 1'b0; level_up = 1'b1;
        repeat (6) cyc();
        level_up = 1'b0;
        chk("sat.bnc.step", int'(b_step), 7); chk("sat.wrp.step", int'(w_step), 7);

        // Reset in the middle of a count, away from a clock edge
        enable = 1'b1; query_x = 10'd320;
        repeat (2) cyc();
        #3 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        model_reset();
        q_exp.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_ticks(1);
        chk("post.bnc.s0", st(0, 0), 3); chk("post.bnc.s1", st(0, 1), 317);
        chk("post.step", int'(b_step), 3);
        query_x = 10'd330;
        run_ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
